// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, req/ack fetch port and single-entry buffer.
// Optional IF_PERF_EN adds fetch/wait performance counters.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] if_addr,
    output logic [31:0] if_inst,
    output logic        stallreq_if
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        bv_q, bv_d;
    logic [31:0] ba_q, ba_d;
    logic [31:0] bi_q, bi_d;
    logic        pend_q, pend_d;
    logic [31:0] da_q, da_d;

    logic        consume;
    logic        redirect;
    logic        ack_ok;
    logic [31:0] tsel;
    logic [31:0] target;
    logic        unused_stall;

    assign unused_stall = ^stall[5:2];

    assign consume  = bv_q & ~stall[1];
    assign redirect = flush | branch_flag;
    assign tsel     = flush ? new_pc : branch_target;
    assign target   = tsel & 32'hFFFF_FFFC;

    assign if_addr     = bv_q ? ba_q : 32'h0;
    assign if_inst     = bv_q ? bi_q : 32'h0;
    assign stallreq_if = (state_q != IDLE) & ~bv_q;

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = pc_q;
        unique case (state_q)
            IDLE: begin
                mem_req = 1'b0;
            end
            RUN: begin
                mem_req = pend_q | (~stall[0] & (~bv_q | consume));
            end
            DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = da_q;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    // ack is only meaningful while a request is on the port
    assign ack_ok = mem_req & mem_ack;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        bv_d    = bv_q;
        ba_d    = ba_q;
        bi_d    = bi_q;
        pend_d  = pend_q;
        da_d    = da_q;
        unique case (state_q)
            IDLE: begin
                state_d = RUN;
                pend_d  = 1'b0;
                if (redirect) pc_d = target;
            end
            RUN: begin
                pend_d = mem_req & ~mem_ack;
                if (redirect) begin
                    bv_d = 1'b0;
                    pc_d = target;
                    if (mem_req & ~mem_ack) begin
                        state_d = DRAIN;
                        da_d    = pc_q;
                        pend_d  = 1'b0;
                    end
                end else begin
                    if (consume) bv_d = 1'b0;
                    if (ack_ok) begin
                        bv_d = 1'b1;
                        ba_d = pc_q;
                        bi_d = mem_rdata;
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            DRAIN: begin
                pend_d = 1'b0;
                if (redirect) pc_d = target;
                if (mem_ack) state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            bv_q    <= 1'b0;
            ba_q    <= 32'h0;
            bi_q    <= 32'h0;
            pend_q  <= 1'b0;
            da_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bv_q    <= bv_d;
            ba_q    <= ba_d;
            bi_q    <= bi_d;
            pend_q  <= pend_d;
            da_q    <= da_d;
        end
    end

`ifdef IF_PERF_EN
    logic [31:0] fcnt_q;
    logic [31:0] wcnt_q;
    logic        fetch_inc;
    logic        wait_inc;

    assign fetch_inc = (state_q == RUN) & ack_ok & ~redirect;
    assign wait_inc  = mem_req & ~mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q <= 32'h0;
            wcnt_q <= 32'h0;
        end else begin
            if (fetch_inc) fcnt_q <= fcnt_q + 32'd1;
            if (wait_inc) wcnt_q <= wcnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fcnt_q;
    assign perf_wait_cnt  = wcnt_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch against a transaction-level fetch model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        stallreq_if;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cnt;
`endif

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .new_pc(new_pc),
        .branch_flag(branch_flag),
        .branch_target(branch_target),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .if_addr(if_addr),
        .if_inst(if_inst),
        .stallreq_if(stallreq_if)
`ifdef IF_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_wait_cnt(perf_wait_cnt)
`endif
    );

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // model: fetch pipeline seen as pc, one buffered insn, one open transaction
    logic [31:0] m_pc, m_ba, m_bi, m_oaddr, m_fc, m_wc;
    bit          m_idle, m_bv, m_ov, m_odrop;

    bit mb;
    int mcnt, mlat;
    int lat_lo, lat_hi;

    task automatic m_reset();
        m_pc    = 32'h0;
        m_idle  = 1'b1;
        m_bv    = 1'b0;
        m_ba    = 32'h0;
        m_bi    = 32'h0;
        m_ov    = 1'b0;
        m_oaddr = 32'h0;
        m_odrop = 1'b0;
        m_fc    = 32'h0;
        m_wc    = 32'h0;
    endtask

    task automatic step(input bit rs, input logic [5:0] st, input bit fl,
                        input logic [31:0] np, input bit bf,
                        input logic [31:0] bt);
        bit          e_req, cons, acc, redir, req_s, ack_s;
        logic [31:0] e_addr, tgt, opc;
        rst = rs;
        stall = st;
        flush = fl;
        new_pc = np;
        branch_flag = bf;
        branch_target = bt;
        #1;
        mem_rdata = mem_addr ^ KEY;
        if (mem_req) begin
            if (!mb) begin
                mb = 1'b1;
                mcnt = 0;
                mlat = $urandom_range(lat_hi, lat_lo);
            end
            mem_ack = (mcnt == mlat);
        end else begin
            mem_ack = 1'($urandom % 2);
        end
        #1;
        cons   = m_bv & ~st[1];
        e_req  = !m_idle && (m_ov || (!st[0] && (!m_bv || cons)));
        e_addr = m_ov ? m_oaddr : m_pc;
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("mem_addr", mem_addr, e_addr);
        chk("if_addr", if_addr, m_bv ? m_ba : 32'h0);
        chk("if_inst", if_inst, m_bv ? m_bi : 32'h0);
        chk("stallreq", 32'(stallreq_if), 32'(!m_idle && !m_bv));
`ifdef IF_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, m_fc);
        chk("perf_wait", perf_wait_cnt, m_wc);
`endif
        req_s = mem_req;
        ack_s = mem_ack;
        @(posedge clk);
        acc   = e_req && ack_s;
        redir = fl || bf;
        tgt   = (fl ? np : bt) & 32'hFFFF_FFFC;
        opc   = m_pc;
        if (rs) begin
            m_reset();
        end else begin
            if (e_req && !ack_s) m_wc = m_wc + 1;
            if (m_idle) begin
                m_idle = 1'b0;
                if (redir) m_pc = tgt;
            end else if (m_ov && m_odrop) begin
                if (redir) m_pc = tgt;
                if (acc) m_ov = 1'b0;
            end else if (redir) begin
                m_bv = 1'b0;
                m_pc = tgt;
                if (e_req && !ack_s) begin
                    m_ov = 1'b1;
                    m_oaddr = opc;
                    m_odrop = 1'b1;
                end else begin
                    m_ov = 1'b0;
                end
            end else begin
                if (cons) m_bv = 1'b0;
                if (acc) begin
                    m_bv = 1'b1;
                    m_ba = opc;
                    m_bi = opc ^ KEY;
                    m_pc = opc + 32'd4;
                    m_fc = m_fc + 1;
                end
                m_ov = e_req && !ack_s;
                m_oaddr = opc;
                m_odrop = 1'b0;
            end
        end
        if (rs) mb = 1'b0;
        else if (req_s && ack_s) mb = 1'b0;
        else if (req_s) mcnt++;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stall = 6'h0;
        flush = 1'b0;
        new_pc = 32'h0;
        branch_flag = 1'b0;
        branch_target = 32'h0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        lat_lo = 0;
        lat_hi = 0;
        mb = 1'b0;
        mcnt = 0;
        mlat = 0;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_ifaddr", if_addr, 32'h0);
        chk("rst_ifinst", if_inst, 32'h0);
        chk("rst_stallreq", 32'(stallreq_if), 32'h0);

        // zero-wait streaming
        repeat (12) step(0, 6'h0, 0, 0, 0, 0);

        // two-cycle memory latency
        lat_lo = 2;
        lat_hi = 2;
        repeat (12) step(0, 6'h0, 0, 0, 0, 0);

        // IF/ID stall with buffer holding 0x10
        lat_lo = 0;
        lat_hi = 0;
        step(1, 6'h0, 0, 0, 0, 0);
        repeat (6) step(0, 6'h0, 0, 0, 0, 0);
        chk("buf_0x10", if_addr, 32'h10);
        repeat (3) step(0, 6'h02, 0, 0, 0, 0);
        repeat (3) step(0, 6'h0, 0, 0, 0, 0);

        // branch while fetch of 0x40 outstanding
        lat_lo = 3;
        lat_hi = 3;
        step(1, 6'h0, 0, 0, 0, 0);
        step(0, 6'h0, 1, 32'h40, 0, 0);
        step(0, 6'h0, 0, 0, 1, 32'h203);
        repeat (8) step(0, 6'h0, 0, 0, 0, 0);

        // flush and branch together with an ack
        lat_lo = 0;
        lat_hi = 0;
        step(0, 6'h0, 1, 32'h80, 1, 32'h100);
        repeat (4) step(0, 6'h0, 0, 0, 0, 0);

        // reset in the middle of a drain
        lat_lo = 3;
        lat_hi = 3;
        step(1, 6'h0, 0, 0, 0, 0);
        step(0, 6'h0, 0, 0, 0, 0);
        step(0, 6'h0, 0, 0, 1, 32'h300);
        step(1, 6'h0, 0, 0, 0, 0);
        repeat (6) step(0, 6'h0, 0, 0, 0, 0);

        // pc wrap at the top of the address space
        lat_lo = 0;
        lat_hi = 0;
        step(0, 6'h0, 1, 32'hFFFF_FFFE, 0, 0);
        repeat (6) step(0, 6'h0, 0, 0, 0, 0);

        // random traffic
        lat_lo = 0;
        lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            bit          rs, fl, bf;
            logic [5:0]  st;
            rs = ($urandom % 200) == 0;
            st = (($urandom % 4) == 0) ? 6'($urandom) : 6'h0;
            fl = ($urandom % 16) == 0;
            bf = ($urandom % 8) == 0;
            step(rs, st, fl, $urandom, bf, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
